instr_adder_measure_ctrl: RTL

//  Host-side driver for the wrapped instrumented ripple adder: latches an operand pair, enables
//  the adder's ring oscillator, and counts oscillator edges over a programmed gate window.

---
 rtl/instr_adder_pkg.sv | 20 ++
 rtl/ring_edge_counter.sv | 71 +++++++
 rtl/instr_adder_measure_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/instr_adder_pkg.sv
// Shared definitions for the instrumented-adder measurement controller.
//  - state_t      : controller FSM states
//  - DEF_*        : default widths for operands, edge count, gate and settle fields
//  - SYNC_FLUSH   : extra settle cycles needed to flush the ring-oscillator synchroniser
package instr_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_CNT_W  = 32;
    localparam int DEF_GATE_W = 16;
    localparam int DEF_SET_W  = 8;
    localparam int SYNC_FLUSH = 2;

endpackage

// File: rtl/ring_edge_counter.sv
// Counts rising edges of an asynchronous ring-oscillator tap.
// Ports:
//  clk_i       system clock
//  rst_i       synchronous active-high reset (clears synchroniser, count, overflow)
//  osc_i       asynchronous oscillator tap
//  clr_i       synchronous clear of count and overflow (wins over en_i)
//  en_i        count enable; a detected rising edge increments only while high
//  count_o     saturating edge count
//  overflow_o  sticky: an edge arrived while the count was already saturated
// Toggling faster than clk_i/2 aliases in the synchroniser and is not detected.
module ring_edge_counter
    import instr_adder_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             osc_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             rise;

    // Stage 1/2 resolve metastability; stage 3 holds the previous synchronised level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= osc_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        rise    = sync2_q & ~prev_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr_i) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (en_i && rise) begin
            // Saturate rather than wrap; the lost edge is flagged instead.
            if (&count_q) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/instr_adder_measure_ctrl.sv
// Host-side driver for the instrumented ripple adder. On an accepted start it
// latches an operand pair, enables the adder ring oscillator, waits a settle
// window, counts oscillator edges over a gate window and returns the count on a
// valid/ready result port.
// Ports:
//  wb_clk_i / wb_rst_i       clock, synchronous active-high reset
//  start_i                   one-cycle start pulse, honoured only in IDLE
//  a_i, b_i                  operands captured on accepted start
//  settle_cycles_i (S)       settle length; settle phase lasts S+2 cycles
//  gate_cycles_i   (G)       measure length in cycles (0 allowed)
//  ring_osc_i                asynchronous oscillator tap
//  a_o, b_o                  registered operands to the adder (held in IDLE)
//  ring_en_o                 oscillator enable, high through SETTLE and MEASURE
//  busy_o                    high whenever not IDLE
//  res_valid_o/res_ready_i   result handshake
//  res_count_o               saturating rising-edge count
//  res_overflow_o            count saturated during the window
module instr_adder_measure_ctrl
    import instr_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int GATE_W = DEF_GATE_W,
    parameter int SET_W  = DEF_SET_W
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic [SET_W-1:0]  settle_cycles_i,
    input  logic [GATE_W-1:0] gate_cycles_i,
    input  logic              ring_osc_i,
    output logic [WIDTH-1:0]  a_o,
    output logic [WIDTH-1:0]  b_o,
    output logic              ring_en_o,
    output logic              busy_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [CNT_W-1:0]  res_count_o,
    output logic              res_overflow_o
);

    // One timer serves both phases; it must hold S+SYNC_FLUSH-1 and G-1.
    localparam int TMR_W = (SET_W + 1 > GATE_W) ? SET_W + 1 : GATE_W;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  a_d;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  b_d;
    logic [GATE_W-1:0] gate_q;
    logic [GATE_W-1:0] gate_d;
    logic [TMR_W-1:0]  timer_q;
    logic [TMR_W-1:0]  timer_d;
    logic              ring_en_q;
    logic              ring_en_d;
    logic              res_valid_q;
    logic              res_valid_d;
    logic              cnt_clr;
    logic              cnt_en;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            gate_q      <= '0;
            timer_q     <= '0;
            ring_en_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            gate_q      <= gate_d;
            timer_q     <= timer_d;
            ring_en_q   <= ring_en_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        gate_d      = gate_q;
        timer_d     = timer_q;
        ring_en_d   = ring_en_q;
        res_valid_d = res_valid_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_d       = a_i;
                    b_d       = b_i;
                    gate_d    = gate_cycles_i;
                    // Counts down to zero inclusive: S+SYNC_FLUSH settle cycles.
                    timer_d   = TMR_W'(settle_cycles_i) + TMR_W'(SYNC_FLUSH - 1);
                    ring_en_d = 1'b1;
                    state_d   = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (timer_q == '0) begin
                    // Edges seen during settling are discarded here.
                    cnt_clr = 1'b1;
                    if (gate_q == '0) begin
                        ring_en_d = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        timer_d = TMR_W'(gate_q) - TMR_W'(1);
                        state_d = ST_MEASURE;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            ST_MEASURE: begin
                cnt_en = 1'b1;
                if (timer_q == '0) begin
                    ring_en_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            ST_DONE: begin
                // Valid rises one cycle after entry, so a consumer already holding
                // ready still sees at least one valid cycle. start_i is ignored here.
                if (!res_valid_q) begin
                    res_valid_d = 1'b1;
                end else if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    cnt_clr     = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    ring_edge_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .osc_i      (ring_osc_i),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .count_o    (res_count_o),
        .overflow_o (res_overflow_o)
    );

    assign a_o         = a_q;
    assign b_o         = b_q;
    assign ring_en_o   = ring_en_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign res_valid_o = res_valid_q;

endmodule
